// File: rtl/adder_pkg.sv
// Shared types and helpers for the pipelined add/subtract unit.
package adder_pkg;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

  function automatic int unsigned num_stages(input int unsigned width, input int unsigned chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational W-bit slice adder with carry in and carry out.
module adder_chunk #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         c_i,
  output logic [W-1:0] s_o,
  output logic         c_o
);

  assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + (W+1)'(c_i);

endmodule

// File: rtl/adder_pipe.sv
// Pipelined add/subtract unit: one CHUNK-bit carry slice per register stage,
// valid/ready handshake on both sides with per-stage stall propagation.
module adder_pipe
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int unsigned STAGES = num_stages(WIDTH, CHUNK);

  if ((WIDTH % CHUNK) != 0 || WIDTH < CHUNK) begin : g_bad_width
    $error("adder_pipe: WIDTH (%0d) must be a non-zero multiple of CHUNK (%0d)", WIDTH, CHUNK);
  end

  logic [STAGES-1:0]            valid_q, carry_q, ld;
  logic                         rdy_q, ovf_q;
  mode_e                        mode_q [STAGES];
  logic [WIDTH-1:0]             opa_q  [STAGES];
  logic [WIDTH-1:0]             opb_q  [STAGES];
  logic [WIDTH-1:0]             res_q  [STAGES];

  logic [STAGES-1:0][WIDTH-1:0] a_in, b_in, res_in, res_d;
  logic [STAGES-1:0][CHUNK-1:0] s_w;
  logic [STAGES-1:0]            cin_w, co_w, vin_w;
  mode_e                        m_in   [STAGES];
  logic                         ovf_d;

  // Stage k may load when it is empty or its content moves on this edge;
  // the chain is resolved from the output side back to the input.
  always_comb begin
    logic go;
    go = out_ready;
    ld = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      go = !valid_q[STAGES-1-i] || go;
      ld[STAGES-1-i] = go;
    end
  end

  assign in_ready = rdy_q && ld[0];

  always_comb begin
    a_in     = '0;
    b_in     = '0;
    res_in   = '0;
    cin_w    = '0;
    vin_w    = '0;
    a_in[0]  = a;
    b_in[0]  = sub ? ~b : b;
    cin_w[0] = sub ? ~c_in : c_in;
    vin_w[0] = in_valid && in_ready;
    m_in[0]  = sub ? MODE_SUB : MODE_ADD;
    for (int unsigned k = 1; k < STAGES; k++) begin
      a_in[k]   = opa_q[k-1];
      b_in[k]   = opb_q[k-1];
      res_in[k] = res_q[k-1];
      cin_w[k]  = carry_q[k-1];
      vin_w[k]  = valid_q[k-1];
      m_in[k]   = mode_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    adder_chunk #(.W(CHUNK)) u_chunk (
      .a_i (a_in[k][k*CHUNK +: CHUNK]),
      .b_i (b_in[k][k*CHUNK +: CHUNK]),
      .c_i (cin_w[k]),
      .s_o (s_w[k]),
      .c_o (co_w[k])
    );
  end

  always_comb begin
    res_d = res_in;
    for (int unsigned k = 0; k < STAGES; k++) begin
      res_d[k][k*CHUNK +: CHUNK] = s_w[k];
    end
    ovf_d = (a_in[STAGES-1][WIDTH-1] == b_in[STAGES-1][WIDTH-1]) &&
            (res_d[STAGES-1][WIDTH-1] != a_in[STAGES-1][WIDTH-1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q   <= 1'b0;
      valid_q <= '0;
      carry_q <= '0;
      ovf_q   <= 1'b0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        opa_q[k]  <= '0;
        opb_q[k]  <= '0;
        res_q[k]  <= '0;
        mode_q[k] <= MODE_ADD;
      end
    end else begin
      rdy_q <= 1'b1;
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (ld[k]) begin
          valid_q[k] <= vin_w[k];
          if (vin_w[k]) begin
            opa_q[k]   <= a_in[k];
            opb_q[k]   <= b_in[k];
            res_q[k]   <= res_d[k];
            carry_q[k] <= co_w[k];
            mode_q[k]  <= m_in[k];
          end
        end
      end
      if (ld[STAGES-1] && vin_w[STAGES-1]) begin
        ovf_q <= ovf_d;
      end
    end
  end

  // The raw carry of the last slice is inverted into a borrow for subtract.
  assign out_valid = valid_q[STAGES-1];
  assign sum       = res_q[STAGES-1];
  assign c_out     = (mode_q[STAGES-1] == MODE_SUB) ? ~carry_q[STAGES-1] : carry_q[STAGES-1];
  assign ovf       = ovf_q;

endmodule
